// File: rtl/iopmp_reg_pkg.sv
// Shared types and helpers for the IOPMP register bank.
package iopmp_reg_pkg;

   // Software-visible access behaviour of one register.
   typedef enum logic [2:0] {
      ACC_RW,
      ACC_RO,
      ACC_W1S,
      ACC_W1C,
      ACC_W1SS,
      ACC_W1CS,
      ACC_HWO
   } acc_e;

   // Request/response handshake state of the bank.
   typedef enum logic {
      ST_IDLE,
      ST_RESP
   } bank_state_e;

   // Read-only and hardware-only registers reject software writes.
   function automatic logic acc_sw_writable(acc_e acc);
      return !(acc == ACC_RO || acc == ACC_HWO);
   endfunction

endpackage

// File: rtl/iopmp_reg_field.sv
// One register of the bank: bit-level next-state logic for all access types.
module iopmp_reg_field
   import iopmp_reg_pkg::*;
#(
   parameter int unsigned          DataWidth = 32,
   parameter acc_e                 Acc       = ACC_RW,
   parameter logic [DataWidth-1:0] InitVal   = '0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sw_we,
   input  logic [DataWidth-1:0] sw_mask,
   input  logic [DataWidth-1:0] sw_wdata,
   input  logic                 hw_we,
   input  logic [DataWidth-1:0] hw_wdata,
   output logic [DataWidth-1:0] q,
   output logic                 qe
);

   logic [DataWidth-1:0] q_d, q_q;
   logic                 qe_d, qe_q;
   logic [DataWidth-1:0] s_bits, sd_bits, base;

   // Merge hardware update and strobed software write according to the access type.
   always_comb begin
      s_bits  = sw_we ? sw_mask : '0;
      sd_bits = s_bits & sw_wdata;
      base    = hw_we ? hw_wdata : q_q;
      q_d     = base;
      unique case (Acc)
         ACC_RW:   q_d = (base & ~s_bits) | sd_bits;
         ACC_W1S:  q_d = base | sd_bits;
         ACC_W1C:  q_d = base & ~sd_bits;
         ACC_W1SS: q_d = q_q | base | sd_bits;
         ACC_W1CS: q_d = q_q & base & ~sd_bits;
         default:  q_d = base;
      endcase
      qe_d = sw_we & (|sw_mask);
   end

   // Register value and software-update pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_q  <= InitVal;
         qe_q <= 1'b0;
      end else begin
         q_q  <= q_d;
         qe_q <= qe_d;
      end
   end

   assign q  = q_q;
   assign qe = qe_q;

endmodule

// File: rtl/iopmp_reg_bank.sv
// IOPMP control/status register bank: decode, error check, handshake FSM and lock.
module iopmp_reg_bank
   import iopmp_reg_pkg::*;
#(
   parameter int unsigned                        NumRegs   = 8,
   parameter int unsigned                        DataWidth = 32,
   parameter int unsigned                        AddrWidth = $clog2(NumRegs) + 2,
   parameter acc_e                               AccTypes [NumRegs] = '{default: ACC_RW},
   parameter logic [NumRegs-1:0][DataWidth-1:0]  InitVals  = '0,
   parameter logic [NumRegs-1:0]                 Lockable  = '0,
   parameter int unsigned                        LockReg   = 0,
   parameter int unsigned                        LockBit   = 0
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic                           req_write,
   input  logic [AddrWidth-1:0]           req_addr,
   input  logic [DataWidth-1:0]           req_wdata,
   input  logic [DataWidth/8-1:0]         req_wstrb,
   output logic                           rsp_valid,
   input  logic                           rsp_ready,
   output logic [DataWidth-1:0]           rsp_rdata,
   output logic                           rsp_err,
   input  logic [NumRegs-1:0]             hw_we,
   input  logic [NumRegs*DataWidth-1:0]   hw_wdata,
   output logic [NumRegs*DataWidth-1:0]   q,
   output logic [NumRegs-1:0]             qe,
   output logic                           locked
);

   localparam int unsigned IdxW = AddrWidth - 2;

   bank_state_e          state_d, state_q;
   logic [DataWidth-1:0] rsp_rdata_d, rsp_rdata_q;
   logic                 rsp_err_d, rsp_err_q;

   logic [IdxW-1:0]      idx;
   logic                 sel_hit, sel_lockable, req_err, accept;
   acc_e                 sel_acc;
   logic [DataWidth-1:0] sel_rdata, wmask;
   logic [NumRegs-1:0]   reg_sw_we;

   assign idx    = req_addr[AddrWidth-1:2];
   assign accept = req_valid && (state_q == ST_IDLE);
   assign locked = q[LockReg*DataWidth + LockBit];

   // Decode the addressed register, classify errors and route the write enable.
   always_comb begin
      sel_hit      = 1'b0;
      sel_acc      = ACC_RW;
      sel_lockable = 1'b0;
      sel_rdata    = '0;
      for (int i = 0; i < NumRegs; i++) begin
         if (idx == IdxW'(i)) begin
            sel_hit      = 1'b1;
            sel_acc      = AccTypes[i];
            sel_lockable = Lockable[i];
            sel_rdata    = q[i*DataWidth +: DataWidth];
         end
      end
      req_err = !sel_hit || (req_addr[1:0] != 2'b00) ||
                (req_write && (!acc_sw_writable(sel_acc) || (sel_lockable && locked)));
      for (int i = 0; i < NumRegs; i++) begin
         reg_sw_we[i] = accept && req_write && !req_err && (idx == IdxW'(i));
      end
      for (int b = 0; b < DataWidth; b++) begin
         wmask[b] = req_wstrb[b/8];
      end
   end

   // One register instance per address slot.
   for (genvar gi = 0; gi < NumRegs; gi++) begin : g_reg
      iopmp_reg_field #(
         .DataWidth (DataWidth),
         .Acc       (AccTypes[gi]),
         .InitVal   (InitVals[gi])
      ) u_field (
         .clk      (clk),
         .rst_n    (rst_n),
         .sw_we    (reg_sw_we[gi]),
         .sw_mask  (wmask),
         .sw_wdata (req_wdata),
         .hw_we    (hw_we[gi]),
         .hw_wdata (hw_wdata[gi*DataWidth +: DataWidth]),
         .q        (q[gi*DataWidth +: DataWidth]),
         .qe       (qe[gi])
      );
   end

   // Handshake state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Next state: accept one request, then hold until the response is taken.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (req_valid) state_d = ST_RESP;
         ST_RESP: if (rsp_ready) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Handshake outputs derived from the current state.
   always_comb begin
      req_ready = (state_q == ST_IDLE);
      rsp_valid = (state_q == ST_RESP);
   end

   // Capture the response at acceptance and clear it once delivered.
   always_comb begin
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (accept) begin
         rsp_err_d   = req_err;
         rsp_rdata_d = (req_write || req_err) ? '0 : sel_rdata;
      end else if (state_q == ST_RESP && rsp_ready) begin
         rsp_err_d   = 1'b0;
         rsp_rdata_d = '0;
      end
   end

   // Response registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule
